md_ioc_multiport: RTL

- Parametrised successor to the three-port controller I/O block; serves NUM_PORTS general-purpose ports of PORT_W bits each, behind one register interface shared by the 68k and Z80 bus bridges.
- Per port: 2-flop input synchroniser, data register, per-bit direction register, and TH-edge interrupt logic with a pending flag.
- Ports aggregate into a single level interrupt toward the VDP external-interrupt path.

---
 rtl/md_ioc_multiport.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/md_ioc_multiport.sv
// md_ioc_multiport: NUM_PORTS general-purpose I/O ports behind one register
// interface. Each port has a 2-flop input synchroniser, a data register, a
// per-bit direction register and TH-edge interrupt logic. The enabled pending
// flags of all ports are ORed into a single registered level interrupt.
// Register map per port: {port, reg}. reg 0=DATA, 1=CTRL, 2=STAT, 3=reserved.
// Optional feature: define IOC_SERIAL_EN to turn reg 3 into SCTRL and add a
// per-port 8N1 serial transmitter on pin 0.
module md_ioc_multiport #(
    parameter int NUM_PORTS   = 3,
    parameter int PORT_W      = 7,
    parameter int PORT_ADDR_W = 3
) (
    input  logic                        MCLK,
    input  logic                        RESET_n,
    input  logic [PORT_ADDR_W+1:0]      addr,
    input  logic                        wr,
    input  logic                        rd,
    input  logic [7:0]                  wdata,
    output logic [7:0]                  rdata,
    output logic                        rvalid,
    input  logic [NUM_PORTS*PORT_W-1:0] pin_i,
    output logic [NUM_PORTS*PORT_W-1:0] pin_o,
    output logic [NUM_PORTS*PORT_W-1:0] pin_d,
    output logic                        irq
);
    localparam int TH = PORT_W - 1;

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_CTRL = 2'd1,
        REG_STAT = 2'd2,
        REG_AUX  = 2'd3
    } reg_e;

    logic [PORT_W-1:0]      data_q  [NUM_PORTS];
    logic [7:0]             ctrl_q  [NUM_PORTS];
    logic [PORT_W-1:0]      sync1_q [NUM_PORTS];
    logic [PORT_W-1:0]      sync2_q [NUM_PORTS];
    logic [NUM_PORTS-1:0]   sync3_q;
    logic [NUM_PORTS-1:0]   pending_q;

    logic [NUM_PORTS-1:0]   wr_hit, rd_hit, th_edge, pend_clr, irq_en;
    logic [7:0]             stat_val [NUM_PORTS];
    logic [7:0]             aux_val  [NUM_PORTS];
    logic [7:0]             rdata_d;
    logic [PORT_ADDR_W-1:0] sel_port;
    reg_e                   sel_reg;

    assign sel_port = addr[PORT_ADDR_W+1:2];
    assign sel_reg  = reg_e'(addr[1:0]);

`ifdef IOC_SERIAL_EN
    logic [2:0]           sctrl_q    [NUM_PORTS];
    logic [9:0]           tx_shift_q [NUM_PORTS];
    logic [3:0]           tx_bits_q  [NUM_PORTS];
    logic [11:0]          tx_cnt_q   [NUM_PORTS];
    logic [NUM_PORTS-1:0] tx_busy_q, ovr_q;
`endif

    // Per-port address decode, TH edge detection and status/aux read values
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            wr_hit[p]   = wr && (int'(sel_port) == p);
            rd_hit[p]   = rd && (int'(sel_port) == p);
            irq_en[p]   = ctrl_q[p][7];
            // TH edges count only while TH is an input; sync3 lags sync2 by one cycle.
            th_edge[p]  = !ctrl_q[p][TH] &&
                          (ctrl_q[p][6] ? (!sync3_q[p] &&  sync2_q[p][TH])
                                        : ( sync3_q[p] && !sync2_q[p][TH]));
            pend_clr[p] = (rd_hit[p] && sel_reg == REG_STAT) ||
                          (wr_hit[p] && sel_reg == REG_STAT && wdata[7]);
`ifdef IOC_SERIAL_EN
            stat_val[p] = {pending_q[p], 5'b0, ovr_q[p], tx_busy_q[p]};
            aux_val[p]  = {5'b0, sctrl_q[p]};
`else
            stat_val[p] = {pending_q[p], 7'b0};
            aux_val[p]  = 8'hFF;
`endif
        end
    end

    // Read mux: unmapped ports and reserved registers read as 8'hFF
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        rdata_d = 8'hFF;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (int'(sel_port) == p) begin
                case (sel_reg)
                    REG_DATA: begin
                        rdata_d = 8'h00;
                        for (int b = 0; b < PORT_W; b++)
                            rdata_d[b] = ctrl_q[p][b] ? data_q[p][b] : sync2_q[p][b];
                    end
                    REG_CTRL: rdata_d = ctrl_q[p];
                    REG_STAT: rdata_d = stat_val[p];
                    default:  rdata_d = aux_val[p];
                endcase
            end
        end
    end

    // Pad drive: DATA to pin_o, CTRL inverted to pin_d (1 = input)
    always_comb begin
        pin_o = '0;
        pin_d = '1;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int b = 0; b < PORT_W; b++) begin
                pin_o[p*PORT_W + b] = data_q[p][b];
                pin_d[p*PORT_W + b] = ~ctrl_q[p][b];
            end
`ifdef IOC_SERIAL_EN
            if (sctrl_q[p][2]) begin
                pin_o[p*PORT_W] = tx_busy_q[p] ? tx_shift_q[p][0] : 1'b1;
                pin_d[p*PORT_W] = 1'b0;
            end
`endif
        end
    end

    // Port state: synchronisers, DATA/CTRL registers and pending flags
    always_ff @(posedge MCLK or negedge RESET_n) begin
        // NOTE: the per-port register arrays are small flop banks, not RAM, so they reset here.
        if (!RESET_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                data_q[p]  <= '0;
                ctrl_q[p]  <= '0;
                sync1_q[p] <= '0;
                sync2_q[p] <= '0;
            end
            sync3_q   <= '0;
            pending_q <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
                sync1_q[p] <= pin_i[p*PORT_W +: PORT_W];
                sync2_q[p] <= sync1_q[p];
                // Tracking sync2 every cycle means a TH direction switch starts from an equal pair.
                sync3_q[p] <= sync2_q[p][TH];
                if (wr_hit[p] && sel_reg == REG_DATA) data_q[p] <= wdata[PORT_W-1:0];
                if (wr_hit[p] && sel_reg == REG_CTRL) ctrl_q[p] <= wdata;
                // A new edge wins over a clear in the same cycle.
                pending_q[p] <= th_edge[p] | (pending_q[p] & ~pend_clr[p]);
            end
        end
    end

    // Registered read port and aggregated interrupt
    always_ff @(posedge MCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            irq    <= 1'b0;
        end else begin
            rvalid <= rd;
            if (rd) rdata <= rdata_d;
            irq <= |(pending_q & irq_en);
        end
    end

`ifdef IOC_SERIAL_EN
    // Serial transmitter: baud divider, 8N1 shifter and overrun flag per port
    always_ff @(posedge MCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                sctrl_q[p]    <= '0;
                tx_shift_q[p] <= '1;
                tx_bits_q[p]  <= '0;
                tx_cnt_q[p]   <= '0;
            end
            tx_busy_q <= '0;
            ovr_q     <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (wr_hit[p] && sel_reg == REG_AUX) sctrl_q[p] <= wdata[2:0];
                if (rd_hit[p] && sel_reg == REG_STAT) ovr_q[p] <= 1'b0;
                if (tx_busy_q[p]) begin
                    if (tx_cnt_q[p] >= (12'd256 << sctrl_q[p][1:0]) - 12'd1) begin
                        tx_cnt_q[p]   <= '0;
                        tx_shift_q[p] <= {1'b1, tx_shift_q[p][9:1]};
                        tx_bits_q[p]  <= tx_bits_q[p] - 4'd1;
                        if (tx_bits_q[p] == 4'd1) tx_busy_q[p] <= 1'b0;
                    end else begin
                        tx_cnt_q[p] <= tx_cnt_q[p] + 12'd1;
                    end
                end
                if (wr_hit[p] && sel_reg == REG_DATA && sctrl_q[p][2]) begin
                    if (tx_busy_q[p]) begin
                        ovr_q[p] <= 1'b1;
                    end else begin
                        tx_shift_q[p] <= {1'b1, wdata, 1'b0};
                        tx_bits_q[p]  <= 4'd10;
                        tx_cnt_q[p]   <= '0;
                        tx_busy_q[p]  <= 1'b1;
                    end
                end
            end
        end
    end
`endif

endmodule
